// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// data access, one outstanding transaction at a time, with per-requester stalls.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic [63:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  logic        sel_q, sel_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_funct3_q, mem_funct3_d;
  logic        grant_if, grant_d, wait_done;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    sel_d        = sel_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    grant_if     = 1'b0;
    grant_d      = 1'b0;
    case (state_q)
      IDLE: begin
        grant_if = if_req && (!d_req || streak_q == MAX_STREAK);
        grant_d  = d_req && !grant_if;
        if (grant_if) begin
          state_d      = REQ;
          owner_d      = OWN_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {if_addr[63:3], 3'b000};
          mem_funct3_d = 3'b010;
          sel_d        = if_addr[2];
          streak_d     = 4'd0;
        end else if (grant_d) begin
          state_d      = REQ;
          owner_d      = OWN_D;
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_funct3_d = d_funct3;
          if (!if_req)                     streak_d = 4'd0;
          else if (streak_q != MAX_STREAK) streak_d = streak_q + 4'd1;
        end
      end
      REQ: begin
        // Once memory has accepted, the response must be drained even if the
        // fetch is flushed in that same cycle; WAIT then discards it.
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end else if (owner_q == OWN_IF && !if_req) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WAIT: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_D;
      streak_q     <= 4'd0;
      sel_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
      mem_funct3_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      sel_q        <= sel_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
    end
  end

  // A flushed fetch still completes on the bus, but its response is dropped here.
  assign wait_done  = !reset && state_q == WAIT && mem_rvalid;
  assign if_rvalid  = wait_done && owner_q == OWN_IF && if_req;
  assign d_rvalid   = wait_done && owner_q == OWN_D;
  assign if_stall   = !reset && if_req && !if_rvalid;
  assign d_stall    = !reset && d_req && !d_rvalid;
  assign if_rdata   = sel_q ? mem_rdata[63:32] : mem_rdata[31:0];
  assign d_rdata    = mem_rdata;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = mem_funct3_q;

  a_d_req_held: assert property (@(posedge clk) disable iff (reset)
    (state_q != IDLE && owner_q == OWN_D) |-> d_req);
endmodule
